// File: rtl/led_pattern_pkg.sv
// Shared types and widths for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        BINARY  = 2'b00,
        CHASE   = 2'b01,
        BREATHE = 2'b10,
        OFF     = 2'b11
    } mode_e;

    localparam int STEP_W = 8;
    localparam int PWM_W  = 8;

    // Triangle wave over the step counter, doubled to span the 8-bit PWM range (0..254).
    function automatic logic [PWM_W-1:0] breathe_duty(input logic [STEP_W-1:0] step);
        logic [6:0] tri_v;
        tri_v = step[7] ? ~step[6:0] : step[6:0];
        return {tri_v, 1'b0};
    endfunction

endpackage

// File: rtl/led_pattern_prescaler.sv
// Free-running prescaler; tick is a registered one-cycle pulse every 2^(PRESCALE_W-r) cycles.
module led_pattern_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] r,
    output logic       tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] w_mask;
    logic                  r_tick;

    // Only the low (PRESCALE_W-r) bits take part; a rate change never disturbs the count.
    assign w_mask = {PRESCALE_W{1'b1}} >> r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + PRESCALE_W'(1);
            r_tick <= &(r_cnt | ~w_mask);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, chase, breathe and off modes selected by sw.
// Define LED_PATTERN_DEBUG_EN to drive tick/PWM/mode/step state onto ja.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [3:0]     sw,
    output logic [NCH-1:0] led,
    output logic [7:0]     ja
);

    logic [3:0]        r_sw_s1;
    logic [3:0]        r_sw_s2;
    logic [STEP_W-1:0] r_step;
    logic [PWM_W-1:0]  r_pwm;
    mode_e             r_mode;
    mode_e             w_mode_nxt;
    mode_e             w_mode_sync;
    logic [NCH-1:0]    r_onehot;
    logic [NCH-1:0]    w_onehot_rot;
    logic [NCH-1:0]    w_onehot_nxt;
    logic [NCH-1:0]    r_led;
    logic [NCH-1:0]    w_led_nxt;
    logic              w_tick;
    logic              w_pwm_bit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    led_pattern_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .r     (r_sw_s2[3:2]),
        .tick  (w_tick)
    );

    assign w_mode_sync = mode_e'(r_sw_s2[1:0]);
    assign w_pwm_bit   = (r_pwm < breathe_duty(r_step));

    generate
        if (NCH == 1) begin : g_rot_single
            assign w_onehot_rot = r_onehot;
        end else begin : g_rot
            assign w_onehot_rot = {r_onehot[NCH-2:0], r_onehot[NCH-1]};
        end
    endgenerate

    // Mode is sampled only on tick; entering a new mode restarts the chase at bit 0.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_onehot_nxt = r_onehot;
        if (w_tick) begin
            w_mode_nxt   = w_mode_sync;
            w_onehot_nxt = (w_mode_sync != r_mode) ? NCH'(1) : w_onehot_rot;
        end
    end

    always_comb begin
        w_led_nxt = '0;
        case (r_mode)
            BINARY:  w_led_nxt = r_step[STEP_W-1 -: NCH];
            CHASE:   w_led_nxt = r_onehot;
            BREATHE: w_led_nxt = {NCH{w_pwm_bit}};
            default: w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode   <= BINARY;
            r_onehot <= NCH'(1);
            r_step   <= '0;
            r_pwm    <= '0;
            r_led    <= '0;
        end else begin
            r_mode   <= w_mode_nxt;
            r_onehot <= w_onehot_nxt;
            r_pwm    <= r_pwm + PWM_W'(1);
            r_led    <= w_led_nxt;
            if (w_tick)
                r_step <= r_step + STEP_W'(1);
        end
    end

    assign led = r_led;

`ifdef LED_PATTERN_DEBUG_EN
    logic [7:0] r_ja;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_ja <= '0;
        else
            r_ja <= {r_step[7:4], r_mode, w_pwm_bit, w_tick};
    end

    assign ja = r_ja;
`else
    assign ja = 8'h00;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen against an arithmetic reference model.
module tb_led_pattern_gen;

    localparam int NCH = 4;
    localparam int PW  = 4;

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic [3:0]     sw    = 4'b0000;
    logic [NCH-1:0] led;
    logic [7:0]     ja;

    led_pattern_gen #(.NCH(NCH), .PRESCALE_W(PW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .sw    (sw),
        .led   (led),
        .ja    (ja)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: cycle counters as plain integers, chase position as an index.
    int         m_ps, m_st, m_md, m_pos, m_pw, m_led, m_ja;
    bit         m_tk;
    logic [3:0] m_h1, m_h2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pwm_on(input int st, input int pw);
        int tri_v;
        tri_v = (st >= 128) ? 255 - st : st;
        return (pw < 2 * tri_v) ? 1 : 0;
    endfunction

    function automatic int led_of(input int md, input int st, input int pos, input int pw);
        case (md)
            0:       return st >> (8 - NCH);
            1:       return 1 << pos;
            2:       return pwm_on(st, pw) != 0 ? (1 << NCH) - 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ps = 0; m_st = 0; m_md = 0; m_pos = 0; m_pw = 0;
        m_tk = 1'b0; m_h1 = 4'h0; m_h2 = 4'h0; m_led = 0; m_ja = 0;
    endtask

    task automatic model_edge();
        int r, per;
        m_led = led_of(m_md, m_st, m_pos, m_pw);
`ifdef LED_PATTERN_DEBUG_EN
        m_ja = (((m_st >> 4) & 15) << 4) | (m_md << 2) | (pwm_on(m_st, m_pw) << 1) | int'(m_tk);
`else
        m_ja = 0;
`endif
        if (m_tk) begin
            if (int'(m_h2[1:0]) != m_md) m_pos = 0;
            else                         m_pos = (m_pos + 1) % NCH;
            m_md = int'(m_h2[1:0]);
            m_st = (m_st + 1) % 256;
        end
        r    = int'(m_h2[3:2]);
        per  = 1 << (PW - r);
        m_tk = ((m_ps % per) == per - 1);
        m_ps = (m_ps + 1) % (1 << PW);
        m_pw = (m_pw + 1) % 256;
        m_h2 = m_h1;
        m_h1 = sw;
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RST_N) model_edge();
        @(negedge CLK);
        chk("led", 32'(led), 32'(m_led));
        chk("ja", 32'(ja), 32'(m_ja));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Entered and left on a falling edge; checks the outputs clear without a clock.
    task automatic do_reset();
        #1 RST_N = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ja", 32'(ja), 32'd0);
        model_reset();
        cycle();
        cycle();
        RST_N = 1'b1;
    endtask

    initial begin
        int k, first, first_val, prev, n;
        bit saw_wrap, saw_on;
        int seq[4];
        seq = '{2, 4, 8, 1};

        @(negedge CLK);
        sw = 4'b0000;
        do_reset();
        run(40);

        // Chase at the fastest rate: walk 0001 -> 0010 -> 0100 -> 1000 -> 0001.
        sw = 4'b1101;
        k = 0;
        while (led !== 4'b0001 && k < 200) begin cycle(); k++; end
        chk("chase_start", 32'(led), 32'd1);
        for (int i = 0; i < 4; i++) begin
            prev = int'(led);
            k = 0;
            while (int'(led) == prev && k < 10) begin cycle(); k++; end
            chk("chase_seq", 32'(led), 32'(seq[i]));
        end

        // Reset mid-chase; the first tick lands 16 cycles after release, led follows 2 later.
        sw = 4'b0001;
        do_reset();
        first = -1; first_val = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (first < 0 && led != '0) begin first = i; first_val = int'(led); end
        end
        chk("first_tick", 32'(first), 32'd18);
        chk("chase_restart", 32'(first_val), 32'd1);

        // Binary at r=3: the step counter must wrap and led must go 1111 -> 0000.
        sw = 4'b1100;
        saw_wrap = 1'b0;
        for (int i = 0; i < 700; i++) begin
            prev = int'(led);
            cycle();
            if (prev == 15 && led == 4'b0000) saw_wrap = 1'b1;
        end
        chk("binary_wrap", 32'(saw_wrap), 32'd1);

        // One-cycle glitch towards chase while OFF, well away from any tick.
        sw = 4'b0011;
        run(40);
        k = 0;
        while (m_ps != 3 && k < 20) begin cycle(); k++; end
        sw = 4'b0001;
        cycle();
        sw = 4'b0011;
        saw_on = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (led != '0) saw_on = 1'b1;
        end
        chk("glitch_ignored", 32'(saw_on), 32'd0);

        // Breathe across a full step sweep, including duty 0 at steps 0 and 255.
        sw = 4'b0010;
        do_reset();
        run(4200);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            sw = 4'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                cycle();
                sw = 4'($urandom);
            end
            n = int'($urandom_range(1, 60));
            run(n);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
